// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: receiver state encoding and
// default constants for a 50 MHz clock at 9600 baud with 16x oversampling.
package uart_pkg;

  localparam int unsigned OS_FACTOR         = 16;
  localparam int unsigned DEF_DATA_BITS     = 8;
  localparam int unsigned DEF_STOP_BIT_TICK = 16;
  localparam int unsigned DEF_BR_LIMIT      = 326;
  localparam int unsigned DEF_BR_BITS       = 9;
  localparam int unsigned DEF_FIFO_EXP      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Circular receive buffer with registered full/empty flags and
// first-word fall-through read data.
//   clk, rst    : clock, asynchronous active-high reset
//   wr, wr_data : push request and byte
//   rd          : pop request
//   rd_data_c   : head entry (combinational), 0 when empty
//   full, empty : registered occupancy flags
module uart_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = DEF_DATA_BITS,
  parameter int unsigned FIFO_EXP  = DEF_FIFO_EXP
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr,
  input  logic                 rd,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic [DATA_BITS-1:0] rd_data_c,
  output logic                 full,
  output logic                 empty
);

  localparam int unsigned DEPTH = 2 ** FIFO_EXP;

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [DATA_BITS-1:0] mem_d [DEPTH];
  logic [FIFO_EXP-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FIFO_EXP-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FIFO_EXP-1:0]  wr_succ_c, rd_succ_c;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 wr_en_c;

  assign wr_succ_c = wr_ptr_q + FIFO_EXP'(1);
  assign rd_succ_c = rd_ptr_q + FIFO_EXP'(1);

  // Pointer and flag update for each read/write combination.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    full_d   = full_q;
    empty_d  = empty_q;
    wr_en_c  = 1'b0;
    case ({wr, rd})
      2'b01: begin
        if (!empty_q) begin
          rd_ptr_d = rd_succ_c;
          full_d   = 1'b0;
          empty_d  = (rd_succ_c == wr_ptr_q);
        end
      end
      2'b10: begin
        if (!full_q) begin
          wr_en_c  = 1'b1;
          wr_ptr_d = wr_succ_c;
          empty_d  = 1'b0;
          full_d   = (wr_succ_c == rd_ptr_q);
        end
      end
      2'b11: begin
        if (empty_q) begin
          // Nothing to pop yet; the write alone goes through.
          wr_en_c  = 1'b1;
          wr_ptr_d = wr_succ_c;
          empty_d  = 1'b0;
          full_d   = (wr_succ_c == rd_ptr_q);
        end else begin
          // When full, the popped head slot is the one being overwritten.
          wr_en_c  = 1'b1;
          wr_ptr_d = wr_succ_c;
          rd_ptr_d = rd_succ_c;
        end
      end
      default: ;
    endcase
  end

  // Storage write.
  always_comb begin
    mem_d = mem_q;
    if (wr_en_c) begin
      mem_d[wr_ptr_q] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign rd_data_c = empty_q ? '0 : mem_q[rd_ptr_q];
  assign full      = full_q;
  assign empty     = empty_q;

endmodule

// File: rtl/uart_rx_top.sv
// UART receive front end: oversampling baud tick, rx synchronizer,
// 8N1 receiver FSM and receive FIFO.
//   clk_50MHz : system clock
//   reset     : asynchronous active-high reset
//   rx        : serial input, idle high, asynchronous
//   read_uart : pop strobe, one entry per high cycle
//   rx_full   : FIFO full
//   rx_empty  : FIFO empty
//   read_data : FIFO head (fall-through), 0 when empty
module uart_rx_top
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS     = DEF_DATA_BITS,
  parameter int unsigned STOP_BIT_TICK = DEF_STOP_BIT_TICK,
  parameter int unsigned BR_LIMIT      = DEF_BR_LIMIT,
  parameter int unsigned BR_BITS       = DEF_BR_BITS,
  parameter int unsigned FIFO_EXP      = DEF_FIFO_EXP
) (
  input  logic                 clk_50MHz,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 read_uart,
  output logic                 rx_full,
  output logic                 rx_empty,
  output logic [DATA_BITS-1:0] read_data
);

  localparam int unsigned S_W = 4;
  localparam int unsigned N_W = $clog2(DATA_BITS + 1);

  localparam logic [S_W-1:0]     S_MID   = S_W'(OS_FACTOR / 2 - 1);
  localparam logic [S_W-1:0]     S_LAST  = S_W'(OS_FACTOR - 1);
  localparam logic [S_W-1:0]     S_STOP  = S_W'(STOP_BIT_TICK - 1);
  localparam logic [N_W-1:0]     N_LAST  = N_W'(DATA_BITS - 1);
  localparam logic [BR_BITS-1:0] BR_WRAP = BR_BITS'(BR_LIMIT - 1);

  logic [BR_BITS-1:0]   br_q, br_d;
  logic                 tick_c;
  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_sync_q, rx_sync_d;
  rx_state_e            state_q, state_d;
  logic [S_W-1:0]       s_q, s_d;
  logic [N_W-1:0]       n_q, n_d;
  logic [DATA_BITS-1:0] b_q, b_d;
  logic                 rx_done_c;

  // Free-running oversample tick.
  assign tick_c = (br_q == BR_WRAP);

  always_comb begin
    br_d = tick_c ? '0 : br_q + BR_BITS'(1);
  end

  // Two-flop synchronizer for the asynchronous serial line.
  always_comb begin
    rx_meta_d = rx;
    rx_sync_d = rx_meta_q;
  end

  // Receiver next-state and datapath.
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    n_d       = n_q;
    b_d       = b_q;
    rx_done_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_sync_q) begin
          s_d     = '0;
          state_d = START;
        end
      end
      START: begin
        if (tick_c) begin
          if (s_q == S_MID) begin
            // Still low at mid start bit: real frame, otherwise a glitch.
            if (!rx_sync_q) begin
              s_d     = '0;
              n_d     = '0;
              state_d = DATA;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      DATA: begin
        if (tick_c) begin
          if (s_q == S_LAST) begin
            s_d = '0;
            b_d = {rx_sync_q, b_q[DATA_BITS-1:1]};
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + N_W'(1);
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      STOP: begin
        if (tick_c) begin
          if (s_q == S_STOP) begin
            // Stop level is not checked; the byte is always delivered.
            rx_done_c = 1'b1;
            state_d   = IDLE;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      br_q      <= '0;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      state_q   <= IDLE;
      s_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
    end else begin
      br_q      <= br_d;
      rx_meta_q <= rx_meta_d;
      rx_sync_q <= rx_sync_d;
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      b_q       <= b_d;
    end
  end

  uart_fifo #(
    .DATA_BITS (DATA_BITS),
    .FIFO_EXP  (FIFO_EXP)
  ) u_fifo (
    .clk       (clk_50MHz),
    .rst       (reset),
    .wr        (rx_done_c),
    .rd        (read_uart),
    .wr_data   (b_q),
    .rd_data_c (read_data),
    .full      (rx_full),
    .empty     (rx_empty)
  );

endmodule

// File: tb/tb_uart_rx_top.sv
// Self-checking bench for uart_rx_top: serial frames are generated from a
// byte value, and the FIFO outputs are compared against a queue model.
module tb_uart_rx_top;

  localparam int unsigned DATA_BITS     = 8;
  localparam int unsigned STOP_BIT_TICK = 16;
  localparam int unsigned BR_LIMIT      = 4;
  localparam int unsigned BR_BITS       = 3;
  localparam int unsigned FIFO_EXP      = 4;
  localparam int unsigned DEPTH         = 1 << FIFO_EXP;
  localparam int unsigned BIT_CYC       = 16 * BR_LIMIT;

  logic                 clk_50MHz = 1'b0;
  logic                 reset     = 1'b1;
  logic                 rx        = 1'b1;
  logic                 read_uart = 1'b0;
  logic                 rx_full;
  logic                 rx_empty;
  logic [DATA_BITS-1:0] read_data;

  logic [7:0] model [$];
  int         n_checks = 0;
  int         n_pass   = 0;
  bit         seen_done;
  logic [7:0] new_byte;

  always #10 clk_50MHz = ~clk_50MHz;

  uart_rx_top #(
    .DATA_BITS     (DATA_BITS),
    .STOP_BIT_TICK (STOP_BIT_TICK),
    .BR_LIMIT      (BR_LIMIT),
    .BR_BITS       (BR_BITS),
    .FIFO_EXP      (FIFO_EXP)
  ) dut (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .rx        (rx),
    .read_uart (read_uart),
    .rx_full   (rx_full),
    .rx_empty  (rx_empty),
    .read_data (read_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(negedge clk_50MHz);
  endtask

  task automatic check_state(input string tag);
    logic [31:0] exp_d;
    exp_d = (model.size() > 0) ? 32'(model[0]) : 32'd0;
    chk({tag, ".empty"}, 32'(rx_empty), 32'(model.size() == 0));
    chk({tag, ".full"},  32'(rx_full),  32'(model.size() == DEPTH));
    chk({tag, ".data"},  32'(read_data), exp_d);
  endtask

  // One 8N1 frame, LSB first, followed by a one-bit idle gap.
  task automatic send_frame(input logic [7:0] d);
    rx = 1'b0;
    cycles(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      cycles(BIT_CYC);
    end
    rx = 1'b1;
    cycles(2 * BIT_CYC);
  endtask

  task automatic deliver(input logic [7:0] d);
    send_frame(d);
    if (model.size() < DEPTH) model.push_back(d);
  endtask

  task automatic pop_one(input string tag);
    check_state(tag);
    read_uart = 1'b1;
    cycles(1);
    read_uart = 1'b0;
    if (model.size() > 0) void'(model.pop_front());
  endtask

  initial begin
    // Reset and idle
    cycles(10);
    reset = 1'b0;
    check_state("reset");
    cycles(5 * BIT_CYC);
    check_state("idle");

    // Three known frames, then read them back
    deliver(8'h41);
    check_state("first");
    deliver(8'h42);
    deliver(8'h43);
    pop_one("abc0");
    pop_one("abc1");
    pop_one("abc2");
    check_state("abc_drained");

    // Start-bit glitch of two ticks
    rx = 1'b0;
    cycles(2 * BR_LIMIT);
    rx = 1'b1;
    cycles(2 * BIT_CYC);
    check_state("glitch");

    // Random bytes with random reads
    for (int i = 0; i < 8; i++) begin
      deliver(8'($urandom));
      if ($urandom_range(0, 1) == 1) pop_one("rnd");
    end
    while (model.size() > 0) pop_one("rnd_drain");

    // Read while empty
    pop_one("empty_rd");
    check_state("empty_after");
    deliver(8'($urandom));
    pop_one("post_empty_rd");

    // Overflow: 17 frames, the last is dropped
    for (int i = 0; i < 17; i++) begin
      deliver(8'(i));
      if (i == 15) check_state("full16");
    end
    check_state("drop17");
    while (model.size() > 0) pop_one("ovf");

    // Refill, then read in the same cycle as the next write while full
    for (int i = 0; i < 16; i++) deliver(8'($urandom));
    check_state("refull");
    new_byte  = 8'($urandom);
    seen_done = 1'b0;
    fork
      send_frame(new_byte);
      begin
        for (int c = 0; c < 20 * BIT_CYC && !seen_done; c++) begin
          @(negedge clk_50MHz);
          if (dut.rx_done_c) begin
            seen_done = 1'b1;
            read_uart = 1'b1;
            @(negedge clk_50MHz);
            read_uart = 1'b0;
          end
        end
      end
    join
    chk("simul_seen", 32'(seen_done), 32'd1);
    if (seen_done) begin
      void'(model.pop_front());
      model.push_back(new_byte);
    end
    check_state("simul");
    while (model.size() > 0) pop_one("simul_drain");

    // Reset mid-frame discards FIFO contents and the partial frame
    deliver(8'hA5);
    deliver(8'h5A);
    rx = 1'b0;
    cycles(3 * BIT_CYC);
    reset = 1'b1;
    cycles(3);
    rx    = 1'b1;
    reset = 1'b0;
    model.delete();
    cycles(2 * BIT_CYC);
    check_state("midrst");
    deliver(8'h3C);
    pop_one("post_rst");
    check_state("end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_top.md
# uart_rx_top

UART receive front end: 16× oversampled baud-tick generator, 8N1 serial receiver and a receive FIFO, all in one clock domain. It sits between the board's serial RX pin and the core logic, which pops received bytes through a single-cycle read strobe. Default parameters target a 50 MHz clock at 9600 baud.

## Interface
- DATA_BITS, 8: data bits per frame.
- STOP_BIT_TICK, 16: oversample ticks spent in the stop phase (16 = one stop bit).
- BR_LIMIT, 326: clock cycles per oversample tick (50e6 / (9600·16) ≈ 326).
- BR_BITS, 9: baud counter width; must satisfy 2^BR_BITS ≥ BR_LIMIT.
- FIFO_EXP, 4: FIFO depth is 2^FIFO_EXP entries.

- clk_50MHz  in  1  system clock, single domain.
- reset  in  1  asynchronous, active-high; clears all state.
- rx  in  1  serial line, idle high, asynchronous to clk.
- read_uart  in  1  pop strobe; one entry removed per high cycle when not empty.
- rx_full  out  1  FIFO holds 2^FIFO_EXP entries.
- rx_empty  out  1  FIFO holds no entries.
- read_data  out  DATA_BITS  head of FIFO (first-word fall-through); 0 when empty.

## Operation
- Baud generator: counter 0..BR_LIMIT-1, wraps to 0; `tick` is high for one cycle when count = BR_LIMIT-1.
- rx passes through a 2-flop synchronizer before use; counts below refer to the synchronized signal.
- Receiver FSM, states IDLE, START, DATA, STOP; tick counter s (4 bit), bit counter n, shift register b.
  - IDLE: on rx = 0, clear s and go to START.
  - START: on each tick, s++; at s = 7 (mid start bit): if rx = 0, clear s and n and go to DATA; if rx = 1, return to IDLE (glitch rejected).
  - DATA: on each tick, s++; at s = 15, clear s and shift rx in at the MSB (b = {rx, b[DATA_BITS-1:1]}, so the frame is LSB-first); after DATA_BITS bits go to STOP.
  - STOP: on each tick, s++; at s = STOP_BIT_TICK-1, pulse rx_done for one cycle and return to IDLE. The stop bit level is not checked; the byte is always delivered.
- FIFO: circular buffer, write and read pointers of width FIFO_EXP plus full/empty flags.
  - Write on rx_done when not full; rx_done while full and not reading drops the byte silently.
  - Read on read_uart when not empty; read_uart while empty is ignored.
  - Simultaneous read and write: when empty, only the write occurs; when full, both occur and the flags are unchanged; otherwise both occur and the count is unchanged.
  - Pointers wrap modulo 2^FIFO_EXP.
  - full sets when a write makes wr_ptr equal rd_ptr; empty sets when a read makes rd_ptr equal wr_ptr.

## Timing
- Reset: baud counter 0, FSM IDLE, s/n/b = 0, pointers 0, rx_empty = 1, rx_full = 0, read_data = 0, synchronizer flops = 1.
- Byte latency: rx_empty falls about 2 + (8 + 16·DATA_BITS + STOP_BIT_TICK)·BR_LIMIT cycles after the start-bit falling edge, i.e. about 9.5 bit times at the defaults. The byte is written on the clock edge after rx_done.
- read_data shows the head entry combinationally. After a read_uart cycle, the next entry (or 0 if now empty) is visible on the following clock edge.
- Flags are registered; both update on the same edge as the pointer change.
- Reset mid-frame aborts the frame and discards FIFO contents.

## Structure
- Shared package uart_pkg: receiver state enum (IDLE, START, DATA, STOP) and default constants (DATA_BITS, BR_LIMIT, oversample factor 16).
- Sub-module uart_fifo (parameters DATA_BITS, FIFO_EXP) holds the buffer.
- Baud generator and receiver FSM are inline in the top.

## Test plan
- Reset: reset high 200 ns then low, rx = 1 -> rx_empty = 1, rx_full = 0, read_data = 0; no write during 5 idle bit times.
- Three frames at 104,167 ns/bit, LSB-first, with 10-bit-time gaps: 0x41, 0x42, 0x43 -> rx_empty falls after the first frame. Three one-cycle read_uart pulses give read_data 0x41, then 0x42, then 0x43; rx_empty = 1 after the third pulse.
- Start glitch: rx low for 2 bit-ticks (652 cycles), then high -> FSM returns to IDLE and no byte is written.
- Overflow: 17 frames 0x00..0x10 with no reads -> rx_full = 1 after the 16th; the 17th is dropped; reads return 0x00..0x0F.
- Full with simultaneous read and write: while full, read_uart asserted in the same cycle as rx_done -> rx_full stays 1; the new byte is stored at the tail.
- Empty read: read_uart pulse with the FIFO empty -> pointers unchanged, rx_empty stays 1, read_data = 0.
